// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock-setting controller: state encoding, field bit
// positions in SET_INC/SET_SEL, and the default timing constants.
package clock_ctrl_pkg;

   localparam int unsigned DEF_TIMEOUT_S  = 60;
   localparam int unsigned DEF_REPEAT_DLY = 8;
   localparam int unsigned DEF_REPEAT_PER = 4;

   localparam int unsigned NUM_FIELDS = 5;
   localparam int unsigned IDX_YEAR   = 0;
   localparam int unsigned IDX_MONTH  = 1;
   localparam int unsigned IDX_DAY    = 2;
   localparam int unsigned IDX_HOUR   = 3;
   localparam int unsigned IDX_MIN    = 4;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_SET_YEAR  = 3'd1,
      ST_SET_MONTH = 3'd2,
      ST_SET_DAY   = 3'd3,
      ST_SET_HOUR  = 3'd4,
      ST_SET_MIN   = 3'd5
   } state_e;

   // One-hot field code of a state; all zero for RUN.
   function automatic logic [NUM_FIELDS-1:0] field_onehot(input state_e st);
      logic [NUM_FIELDS-1:0] oh;
      oh = '0;
      case (st)
         ST_SET_YEAR:  oh[IDX_YEAR]  = 1'b1;
         ST_SET_MONTH: oh[IDX_MONTH] = 1'b1;
         ST_SET_DAY:   oh[IDX_DAY]   = 1'b1;
         ST_SET_HOUR:  oh[IDX_HOUR]  = 1'b1;
         ST_SET_MIN:   oh[IDX_MIN]   = 1'b1;
         default:      oh = '0;
      endcase
      return oh;
   endfunction

   function automatic state_e next_field(input state_e st);
      state_e nxt;
      case (st)
         ST_RUN:       nxt = ST_SET_YEAR;
         ST_SET_YEAR:  nxt = ST_SET_MONTH;
         ST_SET_MONTH: nxt = ST_SET_DAY;
         ST_SET_DAY:   nxt = ST_SET_HOUR;
         ST_SET_HOUR:  nxt = ST_SET_MIN;
         default:      nxt = ST_RUN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// UP key front end: rising-edge press detection plus hold-to-repeat timing,
// counted in 16 Hz ticks. Emits single-cycle press and repeat strobes.
module key_repeat
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
   parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic enable_i,
   input  logic clear_i,
   input  logic up_i,
   input  logic tick_i,
   output logic press_o,
   output logic repeat_o
);

   localparam int unsigned HOLD_MAX = REPEAT_DLY + REPEAT_PER;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] DLY_CNT = HOLD_W'(REPEAT_DLY);
   localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(HOLD_MAX);

   logic              up_q;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;
   logic [HOLD_W-1:0] hold_inc;
   logic              hold_hit;

   assign hold_inc = hold_q + HOLD_W'(1);
   assign hold_hit = (hold_inc == DLY_CNT) || (hold_inc == MAX_CNT);

   assign press_o  = enable_i & up_i & ~up_q;
   // Kept independent of clear_i: the parent derives its clear from repeat_o.
   assign repeat_o = enable_i & up_i & tick_i & hold_hit;

   always_comb begin
      hold_d = hold_q;
      if (!enable_i || !up_i || clear_i) begin
         hold_d = '0;
      end else if (tick_i) begin
         // Fold back to the delay point so the period repeats without wrapping.
         hold_d = (hold_inc == MAX_CNT) ? DLY_CNT : hold_inc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         up_q   <= 1'b0;
         hold_q <= '0;
      end else begin
         up_q   <= up_i;
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time/date setting controller: MODE walks the edited field, UP increments it
// (with auto-repeat), idle seconds time out back to RUN. All outputs registered.
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_S  = DEF_TIMEOUT_S,
   parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
   parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  BTN_MODE,
   input  logic                  BTN_UP,
   input  logic                  TICK_1HZ,
   input  logic                  TICK_16HZ,
   output logic                  RUN_EN,
   output logic [NUM_FIELDS-1:0] SET_INC,
   output logic [NUM_FIELDS-1:0] SET_SEL,
   output logic                  SEC_CLR,
   output logic                  BLINK
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_S + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S);

   state_e state_q;
   state_e state_d;

   logic [TO_W-1:0] to_cnt_q;
   logic [TO_W-1:0] to_cnt_d;
   logic [TO_W-1:0] to_inc;
   logic [3:0]      blink_cnt_q;
   logic [3:0]      blink_cnt_d;

   logic                  run_en_q,  run_en_d;
   logic [NUM_FIELDS-1:0] set_inc_q, set_inc_d;
   logic [NUM_FIELDS-1:0] set_sel_q, set_sel_d;
   logic                  sec_clr_q, sec_clr_d;
   logic                  blink_q,   blink_d;

   logic in_set;
   logic press;
   logic rpt;
   logic inc_evt;
   logic timeout;
   logic state_chg;

   assign in_set = (state_q != ST_RUN);
   assign to_inc = to_cnt_q + TO_W'(1);

   // Any user activity in the same cycle as the final second keeps the edit alive.
   assign timeout   = in_set & TICK_1HZ & ~BTN_MODE & ~press & ~rpt & (to_inc == TO_LAST);
   assign inc_evt   = in_set & ~BTN_MODE & (press | rpt);
   assign state_chg = BTN_MODE | timeout;

   key_repeat #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_key_repeat (
      .clk_i    (CLK),
      .srst_i   (RESET),
      .enable_i (in_set),
      .clear_i  (state_chg),
      .up_i     (BTN_UP),
      .tick_i   (TICK_16HZ),
      .press_o  (press),
      .repeat_o (rpt)
   );

   always_comb begin
      state_d = state_q;
      if (BTN_MODE) begin
         state_d = next_field(state_q);
      end else if (timeout) begin
         state_d = ST_RUN;
      end

      to_cnt_d = to_cnt_q;
      if (!in_set || state_chg || press || rpt) begin
         to_cnt_d = '0;
      end else if (TICK_1HZ) begin
         to_cnt_d = to_inc;
      end

      // Restarting the phase counter gives eight visible ticks after any change.
      blink_cnt_d = blink_cnt_q;
      if ((state_d == ST_RUN) || state_chg || inc_evt) begin
         blink_cnt_d = '0;
      end else if (TICK_16HZ) begin
         blink_cnt_d = blink_cnt_q + 4'd1;
      end

      run_en_d  = (state_d == ST_RUN);
      set_sel_d = field_onehot(state_d);
      set_inc_d = inc_evt ? field_onehot(state_q) : '0;
      sec_clr_d = BTN_MODE & (state_q == ST_SET_MIN);
      blink_d   = (state_d != ST_RUN) & blink_cnt_d[3];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_RUN;
         to_cnt_q    <= '0;
         blink_cnt_q <= '0;
         run_en_q    <= 1'b1;
         set_inc_q   <= '0;
         set_sel_q   <= '0;
         sec_clr_q   <= 1'b0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         run_en_q    <= run_en_d;
         set_inc_q   <= set_inc_d;
         set_sel_q   <= set_sel_d;
         sec_clr_q   <= sec_clr_d;
         blink_q     <= blink_d;
      end
   end

   assign RUN_EN  = run_en_q;
   assign SET_INC = set_inc_q;
   assign SET_SEL = set_sel_q;
   assign SEC_CLR = sec_clr_q;
   assign BLINK   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table, directed corner sequences
// and a long randomized run against a behavioural model of the setting rules.
module tb_clock_set_ctrl;

   localparam int TIMEOUT = 60;
   localparam int DLY     = 8;
   localparam int PER     = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       BTN_MODE = 1'b0;
   logic       BTN_UP = 1'b0;
   logic       TICK_1HZ = 1'b0;
   logic       TICK_16HZ = 1'b0;
   logic       RUN_EN;
   logic [4:0] SET_INC;
   logic [4:0] SET_SEL;
   logic       SEC_CLR;
   logic       BLINK;

   clock_set_ctrl #(
      .TIMEOUT_S  (TIMEOUT),
      .REPEAT_DLY (DLY),
      .REPEAT_PER (PER)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .BTN_MODE  (BTN_MODE),
      .BTN_UP    (BTN_UP),
      .TICK_1HZ  (TICK_1HZ),
      .TICK_16HZ (TICK_16HZ),
      .RUN_EN    (RUN_EN),
      .SET_INC   (SET_INC),
      .SET_SEL   (SET_SEL),
      .SEC_CLR   (SEC_CLR),
      .BLINK     (BLINK)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model: field 0 = RUN, 1..5 = YEAR..MIN; counters are unbounded integers.
   int          m_field;
   int          m_held;
   int          m_idle;
   int          m_blink;
   bit          m_up_prev;
   logic [12:0] m_out;

   localparam logic [12:0] OUT_RUN = 13'b1_00000_00000_0_0;

   function automatic logic [4:0] oh(input int f);
      return (f == 0) ? 5'd0 : 5'(1 << (f - 1));
   endfunction

   function automatic logic [12:0] pack(input bit run, input logic [4:0] sel,
                                        input logic [4:0] inc, input bit sec, input bit blk);
      return {run, sel, inc, sec, blk};
   endfunction

   task automatic model_step(input bit rst, input bit mode, input bit up,
                             input bit t1, input bit t16);
      bit in_set, press, rep, inc, tmo;
      int nf, n;
      if (rst) begin
         m_field = 0; m_held = 0; m_idle = 0; m_blink = 0; m_up_prev = 0;
         m_out = OUT_RUN;
         return;
      end
      in_set = (m_field != 0);
      press  = in_set && up && !m_up_prev;
      rep    = 1'b0;
      if (in_set && up && t16) begin
         n   = m_held + 1;
         rep = (n >= DLY) && (((n - DLY) % PER) == 0);
      end
      inc = in_set && !mode && (press || rep);
      tmo = in_set && !mode && !press && !rep && t1 && (m_idle + 1 == TIMEOUT);
      nf  = mode ? (m_field + 1) % 6 : (tmo ? 0 : m_field);
      if (!in_set || !up || mode || tmo) m_held = 0;
      else if (t16) m_held++;
      if (!in_set || mode || press || rep || tmo) m_idle = 0;
      else if (t1) m_idle++;
      if (nf == 0 || mode || tmo || inc) m_blink = 0;
      else if (t16) m_blink++;
      m_out = pack(nf == 0, oh(nf), inc ? oh(m_field) : 5'd0, mode && (m_field == 5),
                   (nf != 0) && ((m_blink % 16) >= 8));
      m_up_prev = up;
      m_field   = nf;
   endtask

   task automatic step(input bit rst, input bit mode, input bit up, input bit t1, input bit t16);
      RESET = rst; BTN_MODE = mode; BTN_UP = up; TICK_1HZ = t1; TICK_16HZ = t16;
      model_step(rst, mode, up, t1, t16);
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [12:0] exp);
      logic [12:0] got;
      got = {RUN_EN, SET_SEL, SET_INC, SEC_CLR, BLINK};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got {run,sel,inc,secclr,blink}=%b required=%b", name, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
      end
   endtask

   typedef struct {
      bit          rst, mode, up, t1, t16;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int pulses;
      bit r_rst, r_mode, r_up, r_t1, r_t16;

      // {rst, mode, up, t1, t16, expected {run, sel, inc, secclr, blink}}
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'b1_00000_00000_0_0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b0_00001_00000_0_0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'b0_00001_00000_0_0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b0_00010_00000_0_0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'b0_00010_00010_0_0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'b0_00010_00000_0_0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b0_00100_00000_0_0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b0_01000_00000_0_0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b0_10000_00000_0_0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b1_00000_00000_1_0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'b1_00000_00000_0_0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 13'b1_00000_00000_0_0};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 13'b0_00001_00000_0_0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'b0_00001_00000_0_0};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rst, tbl[i].mode, tbl[i].up, tbl[i].t1, tbl[i].t16);
         check($sformatf("table[%0d]", i), tbl[i].exp);
      end

      // Blink phase in SET_YEAR: dark for 8 ticks, lit for 8, dark again.
      for (int i = 1; i <= 17; i++) begin
         step(0, 0, 0, 0, 1);
         check($sformatf("blink_tick%0d", i),
               pack(1'b0, 5'b00001, 5'b00000, 1'b0, (i >= 8) && (i < 16)));
      end
      step(0, 0, 1, 0, 0);
      check("blink_after_inc", 13'b0_00001_00001_0_0);

      // Hold UP in SET_MONTH for 32 ticks of 16 Hz: 8 increments expected.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check("hold_enter_month", 13'b0_00010_00000_0_0);
      pulses = 0;
      step(0, 0, 1, 0, 0);
      check("hold_first_inc", 13'b0_00010_00010_0_0);
      if (SET_INC == 5'b00010) pulses++;
      for (int k = 1; k <= 32; k++) begin
         for (int j = 0; j < 3; j++) begin
            step(0, 0, 1, 0, 0);
            if (SET_INC != 5'b00000) pulses++;
         end
         step(0, 0, 1, (k % 16) == 0, 1);
         check($sformatf("hold_tick%0d", k), m_out);
         if (SET_INC == 5'b00010) pulses++;
      end
      step(0, 0, 0, 0, 1);
      check_int("hold_pulse_count", pulses, 8);

      // MODE and UP rising in the same cycle in SET_DAY.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      check("prio_in_day", 13'b0_00100_00000_0_0);
      step(0, 1, 1, 0, 0);
      check("prio_mode_up", 13'b0_01000_00000_0_0);
      step(0, 0, 1, 0, 0);
      check("prio_after", 13'b0_01000_00000_0_0);

      // Timeout in SET_HOUR, with an UP press at 59 s restarting the count.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < 59; i++) begin
         step(0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0);
      end
      check("to_59s_still_hour", 13'b0_01000_00000_0_0);
      step(0, 0, 1, 0, 0);
      check("to_up_at_59", 13'b0_01000_01000_0_0);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 59; i++) begin
         step(0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0);
      end
      check("to_59s_again", 13'b0_01000_00000_0_0);
      step(0, 0, 0, 1, 0);
      check("to_expire_run", OUT_RUN);
      step(0, 0, 0, 0, 0);
      check("to_no_secclr", OUT_RUN);

      // RESET during auto-repeat in SET_MIN.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check("rst_min_inc", 13'b0_10000_10000_0_0);
      for (int k = 1; k <= 12; k++) begin
         step(0, 0, 1, 0, 1);
         check($sformatf("rst_rep_tick%0d", k), m_out);
         step(0, 0, 1, 0, 0);
      end
      step(1, 0, 1, 0, 1);
      check("rst_abort", OUT_RUN);
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1, 0, i[0]);
         check("rst_quiet", OUT_RUN);
      end

      // Randomized run against the model.
      step(1, 0, 0, 0, 0);
      check("rand_reset", m_out);
      r_up = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         r_rst  = ($urandom_range(0, 2999) == 0);
         r_mode = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 299) == 0) r_up = ~r_up;
         r_t1   = ($urandom_range(0, 5) == 0);
         r_t16  = ($urandom_range(0, 2) == 0);
         step(r_rst, r_mode, r_up, r_t1, r_t16);
         check("random", m_out);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 60, meaning idle seconds in any SET state before automatic return to RUN.
REQ-002 SHALL have parameter REPEAT_DLY, default 8, meaning TICK_16HZ pulses of UP hold before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PER, default 4, meaning TICK_16HZ pulses between auto-repeat increments.
REQ-004 SHALL have port CLK  input  1  the single system clock; all logic on posedge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port BTN_MODE  input  1  debounced one-cycle pulse that advances the set field.
REQ-007 SHALL have port BTN_UP  input  1  debounced level, high while the UP button is held.
REQ-008 SHALL have port TICK_1HZ  input  1  one-cycle pulse, once per second.
REQ-009 SHALL have port TICK_16HZ  input  1  one-cycle pulse, 16 per second.
REQ-010 SHALL have port RUN_EN  output  1  drives the ENABLE input of every time/date counter.
REQ-011 SHALL have port SET_INC  output  5  one-hot single-cycle increment {MIN,HOUR,DAY,MONTH,YEAR}, bit0 = YEAR.
REQ-012 SHALL have port SET_SEL  output  5  one-hot field under edit, zero in RUN.
REQ-013 SHALL have port SEC_CLR  output  1  one-cycle pulse that zeroes the seconds counter.
REQ-014 SHALL have port BLINK  output  1  display blanking phase for the selected field.

Function
REQ-015 SHALL implement FSM states RUN, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR, SET_MIN.
REQ-016 SHALL transition on BTN_MODE: RUN->SET_YEAR->SET_MONTH->SET_DAY->SET_HOUR->SET_MIN->RUN.
REQ-017 SHALL register all outputs; each output reflects the new state one CLK after the triggering input.
REQ-018 SHALL drive RUN_EN=1 only in RUN and 0 in every SET state, freezing the carry chain during edit.
REQ-019 SHALL drive SET_SEL as the one-hot code of the current SET state (YEAR=00001 ... MIN=10000).
REQ-020 SHALL pulse SET_INC[bit of current field] for exactly one cycle, one cycle after a BTN_UP rising edge.
REQ-021 SHALL, while BTN_UP stays high, count TICK_16HZ, issue a first repeat pulse at count REPEAT_DLY, then one pulse every REPEAT_PER ticks.
REQ-022 SHALL clear the hold counter on BTN_UP low, on any state change, and in RUN.
REQ-023 SHALL ignore BTN_UP in RUN and never assert SET_INC in RUN.
REQ-024 SHALL give BTN_MODE priority over BTN_UP and repeat events in the same cycle: state advances, no SET_INC.
REQ-025 SHALL pulse SEC_CLR for one cycle on the SET_MIN->RUN transition via BTN_MODE only, not on timeout.
REQ-026 SHALL count TICK_1HZ in SET states and reload the count to 0 on BTN_MODE, BTN_UP rising edge or repeat pulse.
REQ-027 SHALL force RUN when the count reaches TIMEOUT_S; TIMEOUT_S held seconds of BTN_UP auto-repeat never time out.
REQ-028 SHALL derive BLINK from a 4-bit TICK_16HZ counter: BLINK = counter bit3 in SET states (1 Hz, 50%), 0 in RUN.
REQ-029 SHALL hold BLINK at 0 for the first 8 TICK_16HZ after entering a state or any increment, so the edited value stays visible.
REQ-030 SHALL size the timeout counter ceil(log2(TIMEOUT_S+1)) bits and the hold counter to cover REPEAT_DLY+REPEAT_PER without wrap.

Reset
REQ-031 SHALL, with RESET high at a CLK edge, enter RUN with RUN_EN=1, SET_INC=0, SET_SEL=0, SEC_CLR=0, BLINK=0 and all counters cleared.
REQ-032 SHALL let RESET mid-edit abort immediately to RUN without SEC_CLR or SET_INC pulses.

Structure
REQ-033 SHALL place the state encoding, SET_INC/SET_SEL bit indices and the default timing constants in shared package clock_ctrl_pkg.
REQ-034 SHALL isolate UP edge detection and auto-repeat in one sub-module, key_repeat, which outputs a single-cycle repeat pulse.

Verification
REQ-035 SHALL cover 6 BTN_MODE pulses from RUN -> SET_SEL sequence 00001,00010,00100,01000,10000,00000; SEC_CLR once on the last one.
REQ-036 SHALL cover: in SET_MONTH, UP held 2.0 s -> SET_INC=00010 pulses at 0, 0.5, 0.75, 1.0 ... 2.0 s (8 pulses total).
REQ-037 SHALL cover: BTN_MODE and UP rising edge in the same cycle in SET_DAY -> state SET_HOUR, no SET_INC.
REQ-038 SHALL cover: SET_HOUR with no buttons for 60 TICK_1HZ -> RUN, RUN_EN=1, SEC_CLR stays 0; 59 ticks then UP -> remains SET_HOUR.
REQ-039 SHALL cover: RESET during UP auto-repeat in SET_MIN -> next cycle RUN, all outputs at reset values, no further SET_INC.
